// File: rtl/vga_timing_prog.sv
// Runtime-programmable raster timing generator with scaled framebuffer addressing.
// X/Y/POS registered; DE/H_SYNC/V_SYNC/FRAME_START trail them by LAT cycles.
module vga_timing_prog #(
  parameter int XSZ     = 12,
  parameter int YSZ     = 11,
  parameter int POSSZ   = 19,
  parameter int LAT     = 2,
  parameter int DEF_HA  = 640,
  parameter int DEF_HFP = 16,
  parameter int DEF_HS  = 96,
  parameter int DEF_HBP = 48,
  parameter int DEF_VA  = 480,
  parameter int DEF_VFP = 10,
  parameter int DEF_VS  = 2,
  parameter int DEF_VBP = 33
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CFG_WE,
  input  logic [3:0]       CFG_ADDR,
  input  logic [XSZ-1:0]   CFG_DATA,
  output logic             CFG_PENDING,
  output logic [XSZ-1:0]   X,
  output logic [YSZ-1:0]   Y,
  output logic [POSSZ-1:0] POS,
  output logic             DE,
  output logic             H_SYNC,
  output logic             V_SYNC,
  output logic             FRAME_START
);

  localparam logic [XSZ-1:0] D_HA    = XSZ'(DEF_HA);
  localparam logic [XSZ-1:0] D_HFP   = XSZ'(DEF_HFP);
  localparam logic [XSZ-1:0] D_HS    = XSZ'(DEF_HS);
  localparam logic [XSZ-1:0] D_HBP   = XSZ'(DEF_HBP);
  localparam logic [YSZ-1:0] D_VA    = YSZ'(DEF_VA);
  localparam logic [YSZ-1:0] D_VFP   = YSZ'(DEF_VFP);
  localparam logic [YSZ-1:0] D_VS    = YSZ'(DEF_VS);
  localparam logic [YSZ-1:0] D_VBP   = YSZ'(DEF_VBP);
  localparam logic [3:0]     D_CTRL  = 4'b0011;
  localparam logic [XSZ-1:0] D_HLAST = XSZ'(DEF_HA + DEF_HFP + DEF_HS + DEF_HBP - 1);
  localparam logic [YSZ-1:0] D_VLAST = YSZ'(DEF_VA + DEF_VFP + DEF_VS + DEF_VBP - 1);
  localparam logic [3:0]     PIPE_RST = {1'b0, D_CTRL[0], D_CTRL[1], 1'b0};

  logic [XSZ-1:0]   ha, hfp, hs, hbp, sh_ha, sh_hfp, sh_hs, sh_hbp;
  logic [XSZ-1:0]   sh_ha_n, sh_hfp_n, sh_hs_n, sh_hbp_n;
  logic [YSZ-1:0]   va, vfp, vs, vbp, sh_va, sh_vfp, sh_vs, sh_vbp;
  logic [YSZ-1:0]   sh_va_n, sh_vfp_n, sh_vs_n, sh_vbp_n;
  logic [3:0]       ctrl, sh_ctrl, sh_ctrl_n;
  logic [XSZ-1:0]   h_last;
  logic [YSZ-1:0]   v_last;
  logic             wr_ok, line_end, commit;
  logic [XSZ-1:0]   hs_start, hs_stop;
  logic [YSZ-1:0]   vs_start, vs_stop;
  logic             vis, hs_raw, vs_raw;
  logic [1:0]       s_mask, xs;
  logic             xs_full, y_full;
  logic [POSSZ-1:0] lbase, pos_inc;
  logic [3:0]       raw;

  // Next shadow value, so a write on the commit cycle is folded into the commit.
  always_comb begin
    sh_ha_n  = sh_ha;  sh_hfp_n = sh_hfp; sh_hs_n = sh_hs; sh_hbp_n = sh_hbp;
    sh_va_n  = sh_va;  sh_vfp_n = sh_vfp; sh_vs_n = sh_vs; sh_vbp_n = sh_vbp;
    sh_ctrl_n = sh_ctrl;
    wr_ok = 1'b0;
    if (CFG_WE) begin
      case (CFG_ADDR)
        4'd0: if (CFG_DATA != '0) begin sh_ha_n = CFG_DATA; wr_ok = 1'b1; end
        4'd1: begin sh_hfp_n = CFG_DATA; wr_ok = 1'b1; end
        4'd2: begin sh_hs_n  = CFG_DATA; wr_ok = 1'b1; end
        4'd3: begin sh_hbp_n = CFG_DATA; wr_ok = 1'b1; end
        4'd4: if (CFG_DATA[YSZ-1:0] != '0) begin sh_va_n = CFG_DATA[YSZ-1:0]; wr_ok = 1'b1; end
        4'd5: begin sh_vfp_n = CFG_DATA[YSZ-1:0]; wr_ok = 1'b1; end
        4'd6: begin sh_vs_n  = CFG_DATA[YSZ-1:0]; wr_ok = 1'b1; end
        4'd7: begin sh_vbp_n = CFG_DATA[YSZ-1:0]; wr_ok = 1'b1; end
        4'd8: begin sh_ctrl_n = CFG_DATA[3:0]; wr_ok = 1'b1; end
        default: ;
      endcase
    end
  end

  assign line_end = (X == h_last);
  assign commit   = line_end && (Y == v_last);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      {sh_ha, sh_hfp, sh_hs, sh_hbp} <= {D_HA, D_HFP, D_HS, D_HBP};
      {sh_va, sh_vfp, sh_vs, sh_vbp} <= {D_VA, D_VFP, D_VS, D_VBP};
      {ha, hfp, hs, hbp}             <= {D_HA, D_HFP, D_HS, D_HBP};
      {va, vfp, vs, vbp}             <= {D_VA, D_VFP, D_VS, D_VBP};
      sh_ctrl     <= D_CTRL;
      ctrl        <= D_CTRL;
      h_last      <= D_HLAST;
      v_last      <= D_VLAST;
      CFG_PENDING <= 1'b0;
    end else begin
      {sh_ha, sh_hfp, sh_hs, sh_hbp} <= {sh_ha_n, sh_hfp_n, sh_hs_n, sh_hbp_n};
      {sh_va, sh_vfp, sh_vs, sh_vbp} <= {sh_va_n, sh_vfp_n, sh_vs_n, sh_vbp_n};
      sh_ctrl <= sh_ctrl_n;
      if (commit) begin
        {ha, hfp, hs, hbp} <= {sh_ha_n, sh_hfp_n, sh_hs_n, sh_hbp_n};
        {va, vfp, vs, vbp} <= {sh_va_n, sh_vfp_n, sh_vs_n, sh_vbp_n};
        ctrl        <= sh_ctrl_n;
        h_last      <= sh_ha_n + sh_hfp_n + sh_hs_n + sh_hbp_n - 1'b1;
        v_last      <= sh_va_n + sh_vfp_n + sh_vs_n + sh_vbp_n - 1'b1;
        CFG_PENDING <= 1'b0;
      end else if (wr_ok) begin
        CFG_PENDING <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      X <= '0;
      Y <= '0;
    end else if (line_end) begin
      X <= '0;
      Y <= (Y == v_last) ? '0 : Y + 1'b1;
    end else begin
      X <= X + 1'b1;
    end
  end

  assign hs_start = ha + hfp;
  assign hs_stop  = hs_start + hs;
  assign vs_start = va + vfp;
  assign vs_stop  = vs_start + vs;
  assign vis      = (X < ha) && (Y < va);
  assign hs_raw   = (X >= hs_start) && (X < hs_stop);
  assign vs_raw   = (Y >= vs_start) && (Y < vs_stop);

  // Scale shift 3 behaves as 2, so the group mask is at most 2'b11.
  assign s_mask  = (ctrl[3:2] == 2'd0) ? 2'b00 : (ctrl[3:2] == 2'd1) ? 2'b01 : 2'b11;
  assign xs_full = (xs == s_mask);
  assign y_full  = ((Y[1:0] & s_mask) == s_mask);
  assign pos_inc = (vis && xs_full) ? POS + 1'b1 : POS;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      POS   <= '0;
      lbase <= '0;
      xs    <= '0;
    end else if (commit) begin
      POS   <= '0;
      lbase <= '0;
      xs    <= '0;
    end else if (line_end) begin
      xs <= '0;
      if ((Y < va) && y_full) begin
        lbase <= pos_inc;
        POS   <= pos_inc;
      end else begin
        POS <= lbase;
      end
    end else if (vis) begin
      xs  <= xs_full ? 2'b00 : xs + 1'b1;
      POS <= pos_inc;
    end
  end

  assign raw = {vis, hs_raw ^ ctrl[0], vs_raw ^ ctrl[1], (X == '0) && (Y == '0)};

  generate
    if (LAT == 0) begin : g_nolat
      assign {DE, H_SYNC, V_SYNC, FRAME_START} = raw;
    end else begin : g_lat
      logic [3:0] pipe [LAT];
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          for (int i = 0; i < LAT; i++) pipe[i] <= PIPE_RST;
        end else begin
          pipe[0] <= raw;
          for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign {DE, H_SYNC, V_SYNC, FRAME_START} = pipe[LAT-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_prog.sv
// Directed bench for vga_timing_prog using a reduced default raster (25x13 total, 16x8 visible).
module tb_vga_timing_prog;
  logic        CLK = 1'b0;
  logic        RST;
  logic        CFG_WE;
  logic [3:0]  CFG_ADDR;
  logic [11:0] CFG_DATA;
  logic        CFG_PENDING;
  logic [11:0] X;
  logic [10:0] Y;
  logic [18:0] POS;
  logic        DE, H_SYNC, V_SYNC, FRAME_START;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  vga_timing_prog #(
    .XSZ(12), .YSZ(11), .POSSZ(19), .LAT(2),
    .DEF_HA(16), .DEF_HFP(2), .DEF_HS(4), .DEF_HBP(3),
    .DEF_VA(8),  .DEF_VFP(1), .DEF_VS(2), .DEF_VBP(2)
  ) dut (
    .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA),
    .CFG_PENDING(CFG_PENDING), .X(X), .Y(Y), .POS(POS), .DE(DE), .H_SYNC(H_SYNC),
    .V_SYNC(V_SYNC), .FRAME_START(FRAME_START)
  );

  function automatic logic sig(input int s);
    case (s)
      0: return DE;
      1: return H_SYNC;
      2: return V_SYNC;
      default: return FRAME_START;
    endcase
  endfunction

  task automatic wait_xy(input int x, input int y);
    int n = 0;
    while (!(int'(X) == x && int'(Y) == y) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 2000) begin
      total++; bad++;
      $display("FAIL wait_xy(%0d,%0d): got timeout, want position reached", x, y);
    end
  endtask

  task automatic cfg_write(input int addr, input int data);
    CFG_WE = 1'b1; CFG_ADDR = 4'(addr); CFG_DATA = 12'(data);
    @(negedge CLK);
    CFG_WE = 1'b0;
  endtask

  // Window from one FRAME_START to the next covers exactly one raw frame.
  task automatic measure_frame(input logic hneg, input logic vneg, output int per,
                               output int de_c, output int hs_c, output int vs_c,
                               output int mx, output int my);
    int n = 0;
    per = 0; de_c = 0; hs_c = 0; vs_c = 0; mx = 0; my = 0;
    while (FRAME_START !== 1'b1 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 2000) begin
      total++; bad++;
      $display("FAIL frame_start_wait: got timeout, want pulse");
    end
    do begin
      if (DE === 1'b1) de_c++;
      if (H_SYNC !== hneg) hs_c++;
      if (V_SYNC !== vneg) vs_c++;
      if (int'(X) > mx) mx = int'(X);
      if (int'(Y) > my) my = int'(Y);
      @(negedge CLK);
      per++;
    end while (FRAME_START !== 1'b1 && per < 2000);
  endtask

  task automatic test_reset();
    logic [7:0] got;
    RST = 1'b1; CFG_WE = 1'b0; CFG_ADDR = '0; CFG_DATA = '0;
    repeat (3) @(negedge CLK);
    got = {(X == 0), (Y == 0), (POS == 0), CFG_PENDING, DE, H_SYNC, V_SYNC, FRAME_START};
    total++;
    if (got !== 8'b1110_0110) begin
      bad++;
      $display("FAIL reset_state: got %b want 11100110", got);
    end
    RST = 1'b0;
    #1;
    total++;
    if (X !== 12'd0 || Y !== 11'd0) begin
      bad++;
      $display("FAIL reset_release_xy: got (%0d,%0d) want (0,0)", X, Y);
    end
    @(negedge CLK);
  endtask

  task automatic test_default_timing();
    int g[6];
    int e[6] = '{325, 128, 52, 50, 24, 12};
    measure_frame(1'b1, 1'b1, g[0], g[1], g[2], g[3], g[4], g[5]);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (g[i] !== e[i]) begin
        bad++;
        $display("FAIL default_timing[%0d]: got %0d want %0d", i, g[i], e[i]);
      end
    end
  endtask

  task automatic test_sync_phase();
    int tx[16] = '{2, 3, 17, 18, 19, 20, 23, 24, 1, 2, 1, 2, 1, 2, 1, 2};
    int ty[16] = '{0, 0,  0,  0,  0,  0,  0,  0, 1, 1, 9, 9, 11, 11, 5, 5};
    int ts[16] = '{3, 3,  0,  0,  1,  1,  1,  1, 0, 0, 2, 2, 2, 2, 0, 0};
    logic te[16] = '{1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0, 1};
    logic v;
    wait_xy(0, 0);
    for (int i = 0; i < 16; i++) begin
      wait_xy(tx[i], ty[i]);
      v = sig(ts[i]);
      total++;
      if (v !== te[i]) begin
        bad++;
        $display("FAIL sync_phase sig%0d at (%0d,%0d): got %b want %b", ts[i], tx[i], ty[i], v, te[i]);
      end
    end
  endtask

  task automatic test_scale();
    int tx[12] = '{0, 1, 2, 3, 14, 15, 16, 20, 0, 15, 0, 15};
    int ty[12] = '{0, 0, 0, 0,  0,  0,  0,  0, 1,  1, 2,  7};
    int tp[12] = '{0, 0, 1, 1,  7,  7,  8,  8, 0,  7, 8, 31};
    int ux[3]  = '{20, 0, 5};
    int uy[3]  = '{7, 8, 12};
    int up[3]  = '{32, 32, 32};
    cfg_write(8, 7);
    total++;
    if (CFG_PENDING !== 1'b1) begin
      bad++;
      $display("FAIL scale_pending_set: got %b want 1", CFG_PENDING);
    end
    wait_xy(24, 12);
    @(negedge CLK);
    total++;
    if (CFG_PENDING !== 1'b0) begin
      bad++;
      $display("FAIL scale_pending_clear: got %b want 0", CFG_PENDING);
    end
    for (int i = 0; i < 12; i++) begin
      wait_xy(tx[i], ty[i]);
      total++;
      if (int'(POS) !== tp[i]) begin
        bad++;
        $display("FAIL scale_pos at (%0d,%0d): got %0d want %0d", tx[i], ty[i], POS, tp[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      wait_xy(ux[i], uy[i]);
      total++;
      if (int'(POS) !== up[i]) begin
        bad++;
        $display("FAIL scale_pos_blank at (%0d,%0d): got %0d want %0d", ux[i], uy[i], POS, up[i]);
      end
    end
    wait_xy(0, 0);
    total++;
    if (POS !== 19'd0) begin
      bad++;
      $display("FAIL scale_pos_frame_wrap: got %0d want 0", POS);
    end
  endtask

  task automatic test_commit();
    int g[6];
    int e[6] = '{255, 64, 60, 68, 16, 14};
    wait_xy(0, 5);
    cfg_write(0, 8);
    cfg_write(6, 4);
    cfg_write(8, 0);
    total++;
    if (CFG_PENDING !== 1'b1) begin
      bad++;
      $display("FAIL commit_pending_set: got %b want 1", CFG_PENDING);
    end
    wait_xy(24, 6);
    wait_xy(24, 12);
    total++;
    if (CFG_PENDING !== 1'b1) begin
      bad++;
      $display("FAIL commit_pending_hold: got %b want 1", CFG_PENDING);
    end
    @(negedge CLK);
    total++;
    if (CFG_PENDING !== 1'b0 || X !== 12'd0 || Y !== 11'd0) begin
      bad++;
      $display("FAIL commit_boundary: got pend=%b (%0d,%0d) want pend=0 (0,0)", CFG_PENDING, X, Y);
    end
    measure_frame(1'b0, 1'b0, g[0], g[1], g[2], g[3], g[4], g[5]);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (g[i] !== e[i]) begin
        bad++;
        $display("FAIL commit_timing[%0d]: got %0d want %0d", i, g[i], e[i]);
      end
    end
  endtask

  task automatic test_commit_cycle_write();
    int per, de_c, hs_c, vs_c, mx, my;
    wait_xy(16, 14);
    cfg_write(1, 5);
    total++;
    if (CFG_PENDING !== 1'b0 || X !== 12'd0 || Y !== 11'd0) begin
      bad++;
      $display("FAIL edge_write_boundary: got pend=%b (%0d,%0d) want pend=0 (0,0)", CFG_PENDING, X, Y);
    end
    measure_frame(1'b0, 1'b0, per, de_c, hs_c, vs_c, mx, my);
    total++;
    if (per !== 300 || mx !== 19 || hs_c !== 60) begin
      bad++;
      $display("FAIL edge_write_timing: got per=%0d mx=%0d hs=%0d want per=300 mx=19 hs=60", per, mx, hs_c);
    end
    total++;
    if (CFG_PENDING !== 1'b0) begin
      bad++;
      $display("FAIL edge_write_pending: got %b want 0", CFG_PENDING);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] got;
    int per, de_c, hs_c, vs_c, mx, my;
    cfg_write(0, 12);
    wait_xy(10, 6);
    #2;
    RST = 1'b1;
    #1;
    got = {(X == 0), (Y == 0), (POS == 0), CFG_PENDING, DE, H_SYNC, V_SYNC, FRAME_START};
    total++;
    if (got !== 8'b1110_0110) begin
      bad++;
      $display("FAIL async_reset_state: got %b want 11100110", got);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    measure_frame(1'b1, 1'b1, per, de_c, hs_c, vs_c, mx, my);
    total++;
    if (per !== 325 || de_c !== 128 || mx !== 24 || hs_c !== 52) begin
      bad++;
      $display("FAIL post_reset_timing: got per=%0d de=%0d mx=%0d hs=%0d want 325 128 24 52", per, de_c, mx, hs_c);
    end
    wait_xy(5, 0);
    total++;
    if (POS !== 19'd5) begin
      bad++;
      $display("FAIL post_reset_pos: got %0d want 5", POS);
    end
  endtask

  task automatic test_ignored();
    int per, de_c, hs_c, vs_c, mx, my;
    cfg_write(0, 0);
    cfg_write(12, 7);
    total++;
    if (CFG_PENDING !== 1'b0) begin
      bad++;
      $display("FAIL ignored_pending: got %b want 0", CFG_PENDING);
    end
    wait_xy(0, 0);
    measure_frame(1'b1, 1'b1, per, de_c, hs_c, vs_c, mx, my);
    total++;
    if (per !== 325 || de_c !== 128 || vs_c !== 50) begin
      bad++;
      $display("FAIL ignored_timing: got per=%0d de=%0d vs=%0d want 325 128 50", per, de_c, vs_c);
    end
  endtask

  initial begin
    test_reset();
    test_default_timing();
    test_sync_phase();
    test_scale();
    test_commit();
    test_commit_cycle_write();
    test_reset_midframe();
    test_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
